// File: rtl/pacman_uart_pkg.sv
// Shared types and baud-divider helper for the pacman UART receiver.
package pacman_uart_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  typedef struct packed {
    int unsigned div;
    int unsigned half;
  } uart_div_t;

  function automatic uart_div_t uart_div(input int unsigned clk_hz, input int unsigned baud);
    uart_div_t r;
    r.div  = clk_hz / baud;
    r.half = r.div / 2;
    return r;
  endfunction

endpackage

// File: rtl/pacman_sync2.sv
// Two-flop synchronizer with a parameterised reset value.
module pacman_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pacman_uart_rx.sv
// 8N1 UART receiver: start-bit validation at half bit, data and stop sampled at full bit periods.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to the start-bit midpoint to reject glitches
// DATA  | sampling 8 data bits, LSB first
// STOP  | sampling the stop bit; emits rx_valid or frame_err
module pacman_uart_rx
  import pacman_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam uart_div_t   DCFG = uart_div(CLK_HZ, BAUD);
  localparam int unsigned DIV  = DCFG.div;
  localparam int unsigned HALF = DCFG.half;
  localparam int          TW   = $clog2(DIV);
  localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);

  if (DIV < 4) begin : g_div_chk
    $error("pacman_uart_rx: CLK_HZ / BAUD must be at least 4");
  end

  uart_state_t state, state_nx;
  logic [TW-1:0]         timer, timer_nx;
  logic [2:0]            bit_idx, bit_nx;
  logic [FRAME_BITS-1:0] shreg, shreg_nx;
  logic [7:0]            data_nx;
  logic                  valid_nx, ferr_nx;
  logic                  rxs, rxs_d;

  pacman_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rxs)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rxs_d     <= 1'b1;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      bit_idx   <= bit_nx;
      shreg     <= shreg_nx;
      rx_data   <= data_nx;
      rx_valid  <= valid_nx;
      frame_err <= ferr_nx;
      rxs_d     <= rxs;
    end
  end

  always_comb begin
    state_nx = state;
    timer_nx = timer + 1'b1;
    bit_nx   = bit_idx;
    shreg_nx = shreg;
    data_nx  = rx_data;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (rxs_d && !rxs) state_nx = START;
      end
      START: begin
        if (timer == T_HALF) begin
          timer_nx = '0;
          // Line back high at mid start bit means it was noise, not a frame.
          if (rxs) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            bit_nx   = '0;
          end
        end
      end
      DATA: begin
        if (timer == T_FULL) begin
          timer_nx          = '0;
          shreg_nx[bit_idx] = rxs;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_nx   = bit_idx + 3'd1;
        end
      end
      STOP: begin
        if (timer == T_FULL) begin
          timer_nx = '0;
          state_nx = IDLE;
          if (rxs) begin
            data_nx  = shreg;
            valid_nx = 1'b1;
          end else begin
            ferr_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pacman_uart_rx.sv
// Randomized scoreboard bench for pacman_uart_rx at DIV = 10, HALF = 5.
module tb_pacman_uart_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = 10;
  localparam int HALF   = 5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  always #5 clk = ~clk;

  pacman_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  exp_t       exp_q[$];
  int         vt[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] ref_data = 8'h00;
  logic [7:0] last_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and retires scoreboard entries.
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rstn) begin
        last_data = 8'h00;
      end else begin
        check("pulse_exclusive", {31'd0, rx_valid & frame_err}, 32'd0);
        if (rx_valid || frame_err) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%02h, expected no pulse",
                     rx_valid, frame_err, rx_data);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
            check("pulse_kind_valid", {31'd0, rx_valid}, {31'd0, !e.err});
            check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            if (e.t0 >= 0) begin
              lat = cyc - e.t0;
              total++;
              if (lat < 9*DIV + HALF || lat > 9*DIV + HALF + 5) begin
                bad++;
                $display("FAIL pulse_latency: got %0d cycles expected %0d..%0d",
                         lat, 9*DIV + HALF, 9*DIV + HALF + 5);
              end
            end
            if (rx_valid) vt.push_back(cyc);
          end
          last_data = rx_data;
        end else begin
          check("rx_data_stable", {24'd0, rx_data}, {24'd0, last_data});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(DIV);
  endtask

  // Reference: a good stop bit publishes the byte, a bad one reports an error and keeps the old byte.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    exp_t e;
    if (stop_ok) ref_data = b;
    e.err  = !stop_ok;
    e.data = ref_data;
    e.t0   = cyc;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    tick(n);
    rstn = 1'b1;
    ref_data = 8'h00;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 32'd0);
    tick(5);
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    bit         prev_err;
    int         w;
    int         gap;
    exp_t       e;

    rstn = 1'b0;
    rxd  = 1'b1;
    @(negedge clk);
    tick(3);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    tick(20);

    send_frame(8'h77, 1'b1);
    tick(20);
    drain("single_drain");

    vt.delete();
    send_frame(8'h77, 1'b1);
    send_frame(8'h57, 1'b1);
    tick(10);
    drain("b2b_drain");
    check("b2b_count", vt.size(), 32'd2);
    if (vt.size() == 2) check("b2b_spacing", vt[1] - vt[0], 32'd100);

    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    check("glitch_busy_seen", {31'd0, busy}, 32'd1);
    w = 0;
    while (busy && w < 8) begin
      tick(1);
      w++;
    end
    check("glitch_busy_idle", {31'd0, busy}, 32'd0);
    tick(30);
    check("glitch_no_pending", exp_q.size(), 32'd0);

    do_reset(3);
    tick(10);
    send_frame(8'h64, 1'b0);
    rxd = 1'b1;
    tick(20);
    drain("stop_low_drain");

    b = 8'h72;
    tick(10);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = b[4];
    tick(5);
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    ref_data = 8'h00;
    rxd = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rx_data", {24'd0, rx_data}, 32'd0);
    tick(3*DIV);
    send_frame(8'h72, 1'b1);
    tick(10);
    drain("abort_resend_drain");

    // Line stuck low from reset: synchronizer idles high, so one all-zero frame errors out.
    rxd  = 1'b0;
    rstn = 1'b0;
    tick(3);
    rstn = 1'b1;
    ref_data = 8'h00;
    e.err  = 1'b1;
    e.data = 8'h00;
    e.t0   = -1;
    exp_q.push_back(e);
    tick(200);
    check("stuck_low_one_err", exp_q.size(), 32'd0);
    rxd = 1'b1;
    tick(20);

    prev_err = 1'b0;
    for (int n = 0; n < 24; n++) begin
      gap = prev_err ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) drive_bit(1'b1);
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      prev_err = !ok;
    end
    rxd = 1'b1;
    tick(20);
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
